// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with per-FU result slot buffers
module cdb_arbiter #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int TW    = 5,
  parameter int PW    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*TW-1:0] req_rob_tag,
  input  logic [NREQ*PW-1:0] req_pd,
  input  logic [NREQ-1:0]    req_has_dest,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [TW-1:0]      rob_head,
  input  logic               mispredict,
  input  logic [TW-1:0]      mispredict_tag,
  output logic               cdb_valid,
  output logic [NREQ-1:0]    cdb_src,
  output logic [TW-1:0]      cdb_rob_tag,
  output logic [PW-1:0]      cdb_pd,
  output logic [DW-1:0]      cdb_data,
  output logic               cdb_pd_ready
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Slot buffer state, one row per FU
  logic [DEPTH-1:0] slot_valid [NREQ];
  logic [TW-1:0]    slot_tag   [NREQ][DEPTH];
  logic [PW-1:0]    slot_pd    [NREQ][DEPTH];
  logic             slot_hd    [NREQ][DEPTH];
  logic [DW-1:0]    slot_data  [NREQ][DEPTH];
  logic [RW-1:0]    rr_ptr;

  // Derived selection signals
  logic [TW-1:0]    slot_age   [NREQ][DEPTH];
  logic [TW-1:0]    in_age     [NREQ];
  logic [TW-1:0]    flush_age;
  logic [NREQ-1:0]  nom_valid;
  logic [SW-1:0]    nom_idx    [NREQ];
  logic [TW-1:0]    nom_age    [NREQ];
  logic [SW-1:0]    free_idx   [NREQ];
  logic             win_found;
  logic [RW-1:0]    win;
  logic [SW-1:0]    win_slot;
  logic [TW-1:0]    win_age;
  logic             win_squash;

  // Ages are distances from the ROB head, wrapping modulo 2^TW
  always_comb begin
    flush_age = mispredict_tag - rob_head;
    for (int i = 0; i < NREQ; i++) begin
      in_age[i] = req_rob_tag[i*TW +: TW] - rob_head;
      for (int j = 0; j < DEPTH; j++) begin
        slot_age[i][j] = slot_tag[i][j] - rob_head;
      end
    end
  end

  // Ready and lowest free slot come from registered valids only
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = ~&slot_valid[i];
      free_idx[i]  = '0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (!slot_valid[i][j]) free_idx[i] = SW'(j);
      end
    end
  end

  // Each FU nominates its oldest valid slot; strict compare keeps ties on the lower index
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      nom_valid[i] = 1'b0;
      nom_idx[i]   = '0;
      nom_age[i]   = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (slot_valid[i][j] && (!nom_valid[i] || (slot_age[i][j] < nom_age[i]))) begin
          nom_valid[i] = 1'b1;
          nom_idx[i]   = SW'(j);
          nom_age[i]   = slot_age[i][j];
        end
      end
    end
  end

  // Round-robin across FUs: search rr_ptr..NREQ-1 first, then wrap to 0..rr_ptr-1
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && nom_valid[i] && (RW'(i) >= rr_ptr)) begin
        win_found = 1'b1;
        win       = RW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && nom_valid[i] && (RW'(i) < rr_ptr)) begin
        win_found = 1'b1;
        win       = RW'(i);
      end
    end
    win_slot   = nom_idx[win];
    win_age    = nom_age[win];
    win_squash = mispredict && (win_age > flush_age);
  end

  // Flush, grant and accept; accept targets free slots and grant/flush valid ones, so they never collide
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) slot_valid[i] <= '0;
      rr_ptr       <= '0;
      cdb_valid    <= 1'b0;
      cdb_src      <= '0;
      cdb_rob_tag  <= '0;
      cdb_pd       <= '0;
      cdb_data     <= '0;
      cdb_pd_ready <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (mispredict && (slot_age[i][j] > flush_age)) slot_valid[i][j] <= 1'b0;
        end
      end

      if (win_found) begin
        slot_valid[win][win_slot] <= 1'b0;
        rr_ptr <= (win == RW'(NREQ - 1)) ? '0 : win + 1'b1;
        if (win_squash) begin
          cdb_valid    <= 1'b0;
          cdb_pd_ready <= 1'b0;
        end else begin
          cdb_valid    <= 1'b1;
          cdb_src      <= NREQ'(1) << win;
          cdb_rob_tag  <= slot_tag[win][win_slot];
          cdb_pd       <= slot_pd[win][win_slot];
          cdb_data     <= slot_data[win][win_slot];
          cdb_pd_ready <= slot_hd[win][win_slot] && (slot_pd[win][win_slot] != '0);
        end
      end else begin
        cdb_valid    <= 1'b0;
        cdb_pd_ready <= 1'b0;
      end

      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && !(mispredict && (in_age[i] > flush_age))) begin
          slot_valid[i][free_idx[i]] <= 1'b1;
          slot_tag[i][free_idx[i]]   <= req_rob_tag[i*TW +: TW];
          slot_pd[i][free_idx[i]]    <= req_pd[i*PW +: PW];
          slot_hd[i][free_idx[i]]    <= req_has_dest[i];
          slot_data[i][free_idx[i]]  <= req_data[i*DW +: DW];
        end
      end
    end
  end

endmodule
